exec_trace_buffer: RTL and testbench
====================================

// Module: exec_trace_buffer
// PURPOSE
// - Parametrised on-chip execution trace capture for the single-cycle processor.
// - Records (pc, instruc, statusregister) per retired instruction into a circular buffer.
// - Freezes on stop, PC trigger or full; drains oldest-first over a valid/ready port.
// - Successor to per-cycle $display tracing: synthesizable, configurable depth/width, wrap/one-shot mode.
// PARAMETERS
// - ADDR_W     32  PC width
// - INSTR_W    32  instruction width
// - STAT_W     3   status register width
// - DEPTH      8   entries; power of two, >=2
// - PTR_W      3   log2(DEPTH)
// - WRAP_MODE  0   0 = one-shot (freeze when full); 1 = ring (overwrite oldest)
// PORTS
// - clk        in   1                clock, all logic on posedge
// - reset      in   1                synchronous, active-high
// - arm        in   1                pulse: clear buffer, start capture
// - stop       in   1                pulse: freeze capture, start drain
// - cap_valid  in   1                retire strobe, one entry per high cycle
// - cap_pc     in   ADDR_W           pc of retiring instruction
// - cap_instr  in   INSTR_W          instruction word
// - cap_status in   STAT_W           status register value
// - trig_en    in   1                enable PC trigger
// - trig_pc    in   ADDR_W           trigger PC
// - state      out  2                0 IDLE, 1 CAPTURE, 2 DRAIN
// - count      out  PTR_W+1          valid entries held, saturates at DEPTH
// - wrapped    out  1                ring overwrote at least one entry
// - rd_valid   out  1                rd_data holds an undrained entry
// - rd_ready   in   1                consumer accepts rd_data
// - rd_data    out  ENTRY_W          {[stamp,] status, instr, pc}; ENTRY_W = ADDR_W+INSTR_W+STAT_W[+32]
// BEHAVIOUR
// - One clock; reset is synchronous and active-high.
// - Reset (mid-operation included): state IDLE, count 0, wrapped 0, wptr/rptr 0, rd_valid 0.
// - Storage array is not reset.
// - Priority per cycle: reset > arm > capture write > stop/trigger/full freeze.
// - IDLE: cap_valid ignored; arm -> CAPTURE next cycle, count/wptr/wrapped cleared.
// - CAPTURE, cap_valid=1: entry written at wptr; wptr+1 mod DEPTH; count+1 saturating.
// - CAPTURE, count==DEPTH in ring mode: wrapped<=1.
// - CAPTURE freeze -> DRAIN: stop; cap_valid & trig_en & cap_pc==trig_pc (that entry IS stored);
//   WRAP_MODE=0 and write makes count==DEPTH. Same-cycle cap_valid+stop: entry stored, then freeze.
// - CAPTURE, arm: restart (clears count, wptr, wrapped); stays CAPTURE.
// - Freeze with count==0: go to IDLE, not DRAIN.
// - DRAIN: rptr = wrapped ? wptr : 0 on entry.
// - DRAIN: rd_valid=1 while remaining>0; rd_data = mem[rptr] combinational.
// - DRAIN handshake: on rd_valid&rd_ready, rptr+1 mod DEPTH, remaining-1. rd_data stable while rd_valid&!rd_ready.
// - DRAIN: last transfer -> IDLE next cycle, rd_valid 0. count keeps captured total until next arm.
// - DRAIN: arm aborts drain -> CAPTURE with cleared buffer; stop and cap_valid ignored.
// - Latency: entry readable 1 cycle after its capture cycle once frozen; 1 entry per cycle throughput.
// CONFIGURATION
// - TRACE_CYCLE_STAMP_EN defined: 32-bit free-running cycle counter (reset 0, wraps at 2^32).
//   Counter is sampled into bits [ENTRY_W-1 -: 32] of each entry; ENTRY_W grows by 32.
// - TRACE_CYCLE_STAMP_EN undefined: no counter, no stamp field; all else identical.
// TESTING (DEPTH=8)
// - arm; 3 cap_valid pc=0,4,8; stop -> DRAIN, count=3; drains pc 0,4,8 in order, then IDLE, rd_valid=0.
// - WRAP_MODE=0; arm; 10 captures pc=0..36 step 4 -> freeze after 8th; count=8, wrapped=0; drain pc 0..28.
// - WRAP_MODE=1; arm; 10 captures pc=0..36; stop -> wrapped=1, count=8; drain pc 8..36.
// - trig_en=1, trig_pc=0x10; captures pc 0,4,8,0xC,0x10,0x14 -> freeze at 0x10; count=5; 0x14 not stored.
// - Drain with rd_ready low 3 cycles -> rd_data held stable; reset during DRAIN -> IDLE, count 0 next cycle.
// - TRACE_CYCLE_STAMP_EN: reset released cycle 0, captures at cycles 5 and 9 -> stamps 5 and 9.

Source files
------------

// File: rtl/exec_trace_buffer.sv
// Execution trace buffer: captures (pc, instr, status) per retired instruction
// into a circular buffer, freezes on stop/trigger/full, then drains oldest-first.
// Ports: clk, reset (sync, active-high), arm/stop control, cap_* capture bus,
// trig_en/trig_pc trigger, state/count/wrapped status, rd_valid/rd_ready/rd_data drain.
// Optional macro TRACE_CYCLE_STAMP_EN adds a 32-bit cycle stamp in the top bits of each entry.
module exec_trace_buffer #(
  parameter int ADDR_W    = 32,
  parameter int INSTR_W   = 32,
  parameter int STAT_W    = 3,
  parameter int DEPTH     = 8,
  parameter int PTR_W     = 3,
  parameter int WRAP_MODE = 0,
`ifdef TRACE_CYCLE_STAMP_EN
  localparam int ENTRY_W  = ADDR_W + INSTR_W + STAT_W + 32
`else
  localparam int ENTRY_W  = ADDR_W + INSTR_W + STAT_W
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm,
  input  logic               stop,
  input  logic               cap_valid,
  input  logic [ADDR_W-1:0]  cap_pc,
  input  logic [INSTR_W-1:0] cap_instr,
  input  logic [STAT_W-1:0]  cap_status,
  input  logic               trig_en,
  input  logic [ADDR_W-1:0]  trig_pc,
  output logic [1:0]         state,
  output logic [PTR_W:0]     count,
  output logic               wrapped,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [ENTRY_W-1:0] rd_data
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  state_t             state_q, state_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [PTR_W:0]     rem_q, rem_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic               wrapped_q, wrapped_d;
  logic               we;
  logic               freeze;
  logic               hit;
  logic [ENTRY_W-1:0] entry;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

`ifdef TRACE_CYCLE_STAMP_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk) begin
    if (reset) cyc_q <= '0;
    else       cyc_q <= cyc_q + 32'd1;
  end

  assign entry = {cyc_q, cap_status, cap_instr, cap_pc};
`else
  assign entry = {cap_status, cap_instr, cap_pc};
`endif

  assign hit = cap_valid & trig_en & (cap_pc == trig_pc);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    wrapped_d = wrapped_q;
    we        = 1'b0;
    freeze    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d   = S_CAPTURE;
          count_d   = '0;
          wptr_d    = '0;
          wrapped_d = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (arm) begin
          count_d   = '0;
          wptr_d    = '0;
          wrapped_d = 1'b0;
        end else begin
          if (cap_valid) begin
            we     = 1'b1;
            wptr_d = wptr_q + PTR_W'(1);
            // A write into a full ring overwrites the oldest entry.
            if (count_q != FULL) count_d = count_q + (PTR_W+1)'(1);
            else if (WRAP_MODE != 0) wrapped_d = 1'b1;
          end
          freeze = stop | hit |
                   ((WRAP_MODE == 0) & cap_valid & (count_d == FULL));
          if (freeze) begin
            state_d = (count_d == '0) ? S_IDLE : S_DRAIN;
            // Oldest entry sits at the write pointer once the ring wrapped.
            rptr_d  = wrapped_d ? wptr_d : '0;
            rem_d   = count_d;
          end
        end
      end
      S_DRAIN: begin
        if (arm) begin
          state_d   = S_CAPTURE;
          count_d   = '0;
          wptr_d    = '0;
          wrapped_d = 1'b0;
          rem_d     = '0;
        end else if (rd_valid && rd_ready) begin
          rptr_d = rptr_q + PTR_W'(1);
          rem_d  = rem_q - (PTR_W+1)'(1);
          if (rem_q == (PTR_W+1)'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      wrapped_q <= wrapped_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && we) mem_q[wptr_q] <= entry;
  end

  assign state    = state_q;
  assign count    = count_q;
  assign wrapped  = wrapped_q;
  assign rd_valid = (state_q == S_DRAIN) && (rem_q != '0);
  assign rd_data  = mem_q[rptr_q];

endmodule

// File: tb/tb_exec_trace_buffer.sv
// Bench for exec_trace_buffer: one-shot and ring instances share stimulus;
// directed tables/sequences plus random traffic against a queue-based model.
module tb_exec_trace_buffer;
  localparam int AW = 32;
  localparam int IW = 32;
  localparam int SW = 3;
  localparam int D  = 8;
  localparam int PW = 3;
`ifdef TRACE_CYCLE_STAMP_EN
  localparam int EW = AW + IW + SW + 32;
`else
  localparam int EW = AW + IW + SW;
`endif
  typedef logic [EW-1:0] ent_t;

  logic clk = 1'b0;
  logic reset, arm, stop, cap_valid, trig_en, rd_ready;
  logic [AW-1:0] cap_pc, trig_pc;
  logic [IW-1:0] cap_instr;
  logic [SW-1:0] cap_status;
  logic [1:0] state0, state1;
  logic [PW:0] count0, count1;
  logic wr0, wr1, rv0, rv1;
  ent_t rd0, rd1;

  always #5 clk = ~clk;

  exec_trace_buffer #(.DEPTH(D), .PTR_W(PW), .WRAP_MODE(0)) u_one (
    .clk(clk), .reset(reset), .arm(arm), .stop(stop),
    .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr),
    .cap_status(cap_status), .trig_en(trig_en), .trig_pc(trig_pc),
    .state(state0), .count(count0), .wrapped(wr0),
    .rd_valid(rv0), .rd_ready(rd_ready), .rd_data(rd0));

  exec_trace_buffer #(.DEPTH(D), .PTR_W(PW), .WRAP_MODE(1)) u_ring (
    .clk(clk), .reset(reset), .arm(arm), .stop(stop),
    .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr),
    .cap_status(cap_status), .trig_en(trig_en), .trig_pc(trig_pc),
    .state(state1), .count(count1), .wrapped(wr1),
    .rd_valid(rv1), .rd_ready(rd_ready), .rd_data(rd1));

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: each buffer is a queue of captured entries, oldest first.
  int   m_st  [2];
  int   m_cnt [2];
  bit   m_wr  [2];
  ent_t mq    [2][$];
  logic [31:0] m_cyc = 0;

  task automatic model_step();
    ent_t e;
    bit   frz;
`ifdef TRACE_CYCLE_STAMP_EN
    e = {m_cyc, cap_status, cap_instr, cap_pc};
`else
    e = {cap_status, cap_instr, cap_pc};
`endif
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        m_st[m] = 0; m_cnt[m] = 0; m_wr[m] = 0; mq[m].delete();
      end else if (arm) begin
        m_st[m] = 1; m_cnt[m] = 0; m_wr[m] = 0; mq[m].delete();
      end else if (m_st[m] == 1) begin
        if (cap_valid) begin
          mq[m].push_back(e);
          if (mq[m].size() > D) begin
            void'(mq[m].pop_front());
            m_wr[m] = 1;
          end
        end
        m_cnt[m] = mq[m].size();
        frz = stop || (cap_valid && trig_en && cap_pc == trig_pc) ||
              (m == 0 && cap_valid && mq[m].size() == D);
        if (frz) m_st[m] = (mq[m].size() == 0) ? 0 : 2;
      end else if (m_st[m] == 2 && rd_ready) begin
        void'(mq[m].pop_front());
        if (mq[m].size() == 0) m_st[m] = 0;
      end
    end
    m_cyc = reset ? 32'd0 : m_cyc + 32'd1;
  endtask

  task automatic cmp_model();
    for (int m = 0; m < 2; m++) begin
      bit ev;
      ev = (m_st[m] == 2) && (mq[m].size() > 0);
      chk($sformatf("m%0d state", m), m ? state1 : state0, 128'(m_st[m]));
      chk($sformatf("m%0d count", m), m ? count1 : count0, 128'(m_cnt[m]));
      chk($sformatf("m%0d wrapped", m), m ? wr1 : wr0, 128'(m_wr[m]));
      chk($sformatf("m%0d rd_valid", m), m ? rv1 : rv0, 128'(ev));
      if (ev) chk($sformatf("m%0d rd_data", m), m ? rd1 : rd0, 128'(mq[m][0]));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  task automatic drive(bit a, bit s, bit cv, logic [31:0] pc, bit rr);
    arm = a; stop = s; cap_valid = cv; cap_pc = pc; rd_ready = rr;
    cap_instr = $urandom;
    cap_status = SW'($urandom);
    tick();
  endtask

  typedef struct {
    bit a; bit s; bit cv; logic [31:0] pc; bit rr;
    int est; int ecnt; bit erv; logic [31:0] epc;
  } vec_t;
  vec_t tbl [8];

  initial begin
    ent_t tmp;
    for (int m = 0; m < 2; m++) begin
      m_st[m] = 0; m_cnt[m] = 0; m_wr[m] = 0;
    end
    reset = 1; arm = 0; stop = 0; cap_valid = 0; cap_pc = 0;
    cap_instr = 0; cap_status = 0; trig_en = 0; trig_pc = 0; rd_ready = 0;
    tick(); tick();
    chk("reset state", state0, 0);
    chk("reset count", count1, 0);
    reset = 0;

    // Basic capture of three entries, then drain in order.
    tbl[0] = '{1, 0, 0, 32'h0, 0, 1, 0, 0, 32'h0};
    tbl[1] = '{0, 0, 1, 32'h0, 0, 1, 1, 0, 32'h0};
    tbl[2] = '{0, 0, 1, 32'h4, 0, 1, 2, 0, 32'h0};
    tbl[3] = '{0, 0, 1, 32'h8, 0, 1, 3, 0, 32'h0};
    tbl[4] = '{0, 1, 0, 32'h0, 0, 2, 3, 1, 32'h0};
    tbl[5] = '{0, 0, 0, 32'h0, 1, 2, 3, 1, 32'h4};
    tbl[6] = '{0, 0, 0, 32'h0, 1, 2, 3, 1, 32'h8};
    tbl[7] = '{0, 0, 0, 32'h0, 1, 0, 3, 0, 32'h0};
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].a, tbl[i].s, tbl[i].cv, tbl[i].pc, tbl[i].rr);
      chk($sformatf("tbl%0d state", i), state0, 128'(tbl[i].est));
      chk($sformatf("tbl%0d count", i), count1, 128'(tbl[i].ecnt));
      chk($sformatf("tbl%0d rv", i), rv0, 128'(tbl[i].erv));
      if (tbl[i].erv) chk($sformatf("tbl%0d pc", i), rd1[AW-1:0], 128'(tbl[i].epc));
    end

    // Ten captures: one-shot freezes when full, ring overwrites oldest.
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, 0, 1, 32'(4 * i), 0);
    drive(0, 1, 0, 0, 0);
    chk("full one state", state0, 2);
    chk("full one count", count0, 8);
    chk("full one wrapped", wr0, 0);
    chk("full ring state", state1, 2);
    chk("full ring count", count1, 8);
    chk("full ring wrapped", wr1, 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("one drain%0d", i), rd0[AW-1:0], 128'(4 * i));
      chk($sformatf("ring drain%0d", i), rd1[AW-1:0], 128'(4 * i + 8));
      drive(0, 0, 0, 0, 1);
    end
    chk("drain end state", state1, 0);
    chk("drain end rv", rv0, 0);
    chk("drain keep count", count0, 8);

    // PC trigger freezes on the matching entry; later pc is not stored.
    trig_en = 1; trig_pc = 32'h10;
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 0, 1, 32'(4 * i), 0);
    chk("trig state", state0, 2);
    chk("trig count one", count0, 5);
    chk("trig count ring", count1, 5);
    trig_en = 0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0);
      chk("stall data", rd0[AW-1:0], 0);
      chk("stall rv", rv1, 1);
    end
    drive(0, 0, 0, 0, 1);
    chk("after stall", rd1[AW-1:0], 4);
    reset = 1;
    drive(0, 0, 0, 0, 0);
    reset = 0;
    chk("rst drain state", state0, 0);
    chk("rst drain count", count1, 0);
    chk("rst drain rv", rv0, 0);

`ifdef TRACE_CYCLE_STAMP_EN
    reset = 1;
    drive(0, 0, 0, 0, 0);
    reset = 0;
    for (int c = 0; c <= 10; c++)
      drive(c == 0, c == 10, c == 5 || c == 9, 32'(c), 0);
    tmp = rd0;
    chk("stamp 5", tmp[EW-1 -: 32], 5);
    drive(0, 0, 0, 0, 1);
    tmp = rd1;
    chk("stamp 9", tmp[EW-1 -: 32], 9);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      trig_en = $urandom_range(0, 1);
      trig_pc = 32'h20;
      drive($urandom_range(0, 29) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 1), 32'($urandom_range(0, 15) * 4),
            $urandom_range(0, 9) < 7);
    end
    reset = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
